draw_cmd_scheduler: RTL and testbench

//  Round-robin scheduler sharing one superpixel rectangle draw engine (and thus the VGA RAM write port) among

---
 rtl/draw_cmd_scheduler_pkg.sv | 22 ++
 rtl/draw_cmd_scheduler_rr_arbiter.sv | 32 +++
 rtl/draw_cmd_scheduler.sv | 214 +++++++++++++++++++++
 tb/tb_draw_cmd_scheduler.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/draw_cmd_scheduler_pkg.sv
// Shared constants and FSM encoding for the rectangle draw command scheduler.
package draw_cmd_scheduler_pkg;

  localparam int unsigned DEF_NREQ           = 4;
  localparam int unsigned DEF_SPIXEL_X_WIDTH = 6;
  localparam int unsigned DEF_SPIXEL_Y_WIDTH = 6;
  localparam int unsigned DEF_SPIXEL_X_MAX   = 63;
  localparam int unsigned DEF_SPIXEL_Y_MAX   = 47;
  localparam int unsigned DEF_COLOR_ID_WIDTH = 8;
  localparam int unsigned DEF_TO_WIDTH       = 19;
  localparam int unsigned DEF_TIMEOUT        = 310000;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ACCEPT = 3'd1,
    ST_LAUNCH = 3'd2,
    ST_BUSY   = 3'd3,
    ST_DONE   = 3'd4,
    ST_ABORT  = 3'd5
  } state_e;

endpackage

// File: rtl/draw_cmd_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or above ptr, wrapping mod NREQ.
module rr_arbiter
  import draw_cmd_scheduler_pkg::*;
#(
  parameter int unsigned NREQ  = DEF_NREQ,
  parameter int unsigned IDX_W = $clog2(NREQ)
) (
  input  logic [NREQ-1:0]  req,
  input  logic [IDX_W-1:0] ptr,
  output logic [NREQ-1:0]  grant_oh_c,
  output logic [IDX_W-1:0] grant_idx_c,
  output logic             any_c
);

  function automatic logic [IDX_W-1:0] wrap_add(input logic [IDX_W-1:0] base,
                                                 input int unsigned off);
    return IDX_W'((32'(base) + off) % NREQ);
  endfunction

  always_comb begin
    grant_idx_c = '0;
    any_c       = 1'b0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      if (!any_c && req[wrap_add(ptr, k)]) begin
        any_c       = 1'b1;
        grant_idx_c = wrap_add(ptr, k);
      end
    end
    grant_oh_c = any_c ? (NREQ'(1) << grant_idx_c) : '0;
  end

endmodule

// File: rtl/draw_cmd_scheduler.sv
// Round-robin scheduler sharing one rectangle draw engine among NREQ clients,
// with corner normalisation/clamping and a watchdog that aborts hung draws.
module draw_cmd_scheduler
  import draw_cmd_scheduler_pkg::*;
#(
  parameter int unsigned NREQ           = DEF_NREQ,
  parameter int unsigned SPIXEL_X_WIDTH = DEF_SPIXEL_X_WIDTH,
  parameter int unsigned SPIXEL_Y_WIDTH = DEF_SPIXEL_Y_WIDTH,
  parameter int unsigned SPIXEL_X_MAX   = DEF_SPIXEL_X_MAX,
  parameter int unsigned SPIXEL_Y_MAX   = DEF_SPIXEL_Y_MAX,
  parameter int unsigned COLOR_ID_WIDTH = DEF_COLOR_ID_WIDTH,
  parameter int unsigned TO_WIDTH       = DEF_TO_WIDTH,
  parameter int unsigned TIMEOUT        = DEF_TIMEOUT
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [NREQ-1:0]                    req_vld,
  output logic [NREQ-1:0]                    req_rdy,
  input  logic [NREQ*SPIXEL_X_WIDTH-1:0]     req_x0,
  input  logic [NREQ*SPIXEL_Y_WIDTH-1:0]     req_y0,
  input  logic [NREQ*SPIXEL_X_WIDTH-1:0]     req_x1,
  input  logic [NREQ*SPIXEL_Y_WIDTH-1:0]     req_y1,
  input  logic [NREQ*COLOR_ID_WIDTH-1:0]     req_color,
  output logic [NREQ-1:0]                    ack,
  output logic [NREQ-1:0]                    err,
  output logic                               busy,
  output logic [SPIXEL_X_WIDTH-1:0]          eng_x0,
  output logic [SPIXEL_Y_WIDTH-1:0]          eng_y0,
  output logic [SPIXEL_X_WIDTH-1:0]          eng_x1,
  output logic [SPIXEL_Y_WIDTH-1:0]          eng_y1,
  output logic [COLOR_ID_WIDTH-1:0]          eng_data,
  output logic                               eng_vld,
  input  logic                               eng_done,
  output logic                               eng_rst
);

  localparam int unsigned IDX_W = $clog2(NREQ);
  localparam int unsigned XW    = SPIXEL_X_WIDTH;
  localparam int unsigned YW    = SPIXEL_Y_WIDTH;
  localparam int unsigned CW    = COLOR_ID_WIDTH;

  state_e           state_q, state_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [IDX_W-1:0] grant_q, grant_d;
  logic [TO_WIDTH-1:0] wd_q, wd_d;
  logic [NREQ-1:0]  req_rdy_q, req_rdy_d;
  logic [NREQ-1:0]  ack_q, ack_d;
  logic [NREQ-1:0]  err_q, err_d;
  logic             busy_q, busy_d;
  logic             eng_vld_q, eng_vld_d;
  logic             eng_rst_q, eng_rst_d;
  logic [XW-1:0]    eng_x0_q, eng_x0_d, eng_x1_q, eng_x1_d;
  logic [YW-1:0]    eng_y0_q, eng_y0_d, eng_y1_q, eng_y1_d;
  logic [CW-1:0]    eng_data_q, eng_data_d;

  logic [NREQ-1:0]  arb_oh_c;
  logic [IDX_W-1:0] arb_idx_c;
  logic             arb_any_c;
  logic [NREQ-1:0]  grant_oh_c;

  logic [XW-1:0] x0_a [NREQ];
  logic [XW-1:0] x1_a [NREQ];
  logic [YW-1:0] y0_a [NREQ];
  logic [YW-1:0] y1_a [NREQ];
  logic [CW-1:0] col_a [NREQ];

  logic [XW-1:0] x_lo_c, x_hi_c;
  logic [YW-1:0] y_lo_c, y_hi_c;

  rr_arbiter #(
    .NREQ  (NREQ),
    .IDX_W (IDX_W)
  ) u_arb (
    .req         (req_vld),
    .ptr         (ptr_q),
    .grant_oh_c  (arb_oh_c),
    .grant_idx_c (arb_idx_c),
    .any_c       (arb_any_c)
  );

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
    assign x0_a[gi]  = req_x0[gi*XW +: XW];
    assign x1_a[gi]  = req_x1[gi*XW +: XW];
    assign y0_a[gi]  = req_y0[gi*YW +: YW];
    assign y1_a[gi]  = req_y1[gi*YW +: YW];
    assign col_a[gi] = req_color[gi*CW +: CW];
  end

  assign grant_oh_c = NREQ'(1) << grant_q;

  function automatic logic [XW-1:0] clamp_x(input logic [XW-1:0] v);
    return (32'(v) > SPIXEL_X_MAX) ? XW'(SPIXEL_X_MAX) : v;
  endfunction

  function automatic logic [YW-1:0] clamp_y(input logic [YW-1:0] v);
    return (32'(v) > SPIXEL_Y_MAX) ? YW'(SPIXEL_Y_MAX) : v;
  endfunction

  // Granted client's corners sorted to top-left/bottom-right, then clamped to screen.
  always_comb begin
    x_lo_c = clamp_x((x0_a[grant_q] < x1_a[grant_q]) ? x0_a[grant_q] : x1_a[grant_q]);
    x_hi_c = clamp_x((x0_a[grant_q] < x1_a[grant_q]) ? x1_a[grant_q] : x0_a[grant_q]);
    y_lo_c = clamp_y((y0_a[grant_q] < y1_a[grant_q]) ? y0_a[grant_q] : y1_a[grant_q]);
    y_hi_c = clamp_y((y0_a[grant_q] < y1_a[grant_q]) ? y1_a[grant_q] : y0_a[grant_q]);
  end

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    grant_d    = grant_q;
    wd_d       = wd_q;
    req_rdy_d  = '0;
    ack_d      = '0;
    err_d      = '0;
    eng_vld_d  = 1'b0;
    eng_rst_d  = 1'b0;
    eng_x0_d   = eng_x0_q;
    eng_y0_d   = eng_y0_q;
    eng_x1_d   = eng_x1_q;
    eng_y1_d   = eng_y1_q;
    eng_data_d = eng_data_q;

    unique case (state_q)
      ST_IDLE: begin
        if (arb_any_c) begin
          state_d   = ST_ACCEPT;
          grant_d   = arb_idx_c;
          req_rdy_d = arb_oh_c;
        end
      end
      ST_ACCEPT: begin
        state_d    = ST_LAUNCH;
        eng_x0_d   = x_lo_c;
        eng_x1_d   = x_hi_c;
        eng_y0_d   = y_lo_c;
        eng_y1_d   = y_hi_c;
        eng_data_d = col_a[grant_q];
        eng_vld_d  = 1'b1;
        ptr_d      = IDX_W'((32'(grant_q) + 32'd1) % NREQ);
      end
      ST_LAUNCH: begin
        state_d = ST_BUSY;
        wd_d    = '0;
      end
      // A done pulse in the timeout cycle still counts as completion.
      ST_BUSY: begin
        if (eng_done) begin
          state_d = ST_DONE;
          ack_d   = grant_oh_c;
        end else if (wd_q == TO_WIDTH'(TIMEOUT - 1)) begin
          state_d   = ST_ABORT;
          err_d     = grant_oh_c;
          eng_rst_d = 1'b1;
        end else begin
          wd_d = wd_q + 1'b1;
        end
      end
      ST_DONE:  state_d = ST_IDLE;
      ST_ABORT: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      ptr_q      <= '0;
      grant_q    <= '0;
      wd_q       <= '0;
      req_rdy_q  <= '0;
      ack_q      <= '0;
      err_q      <= '0;
      busy_q     <= 1'b0;
      eng_vld_q  <= 1'b0;
      eng_rst_q  <= 1'b0;
      eng_x0_q   <= '0;
      eng_y0_q   <= '0;
      eng_x1_q   <= '0;
      eng_y1_q   <= '0;
      eng_data_q <= '0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      grant_q    <= grant_d;
      wd_q       <= wd_d;
      req_rdy_q  <= req_rdy_d;
      ack_q      <= ack_d;
      err_q      <= err_d;
      busy_q     <= busy_d;
      eng_vld_q  <= eng_vld_d;
      eng_rst_q  <= eng_rst_d;
      eng_x0_q   <= eng_x0_d;
      eng_y0_q   <= eng_y0_d;
      eng_x1_q   <= eng_x1_d;
      eng_y1_q   <= eng_y1_d;
      eng_data_q <= eng_data_d;
    end
  end

  assign req_rdy  = req_rdy_q;
  assign ack      = ack_q;
  assign err      = err_q;
  assign busy     = busy_q;
  assign eng_vld  = eng_vld_q;
  assign eng_rst  = eng_rst_q;
  assign eng_x0   = eng_x0_q;
  assign eng_y0   = eng_y0_q;
  assign eng_x1   = eng_x1_q;
  assign eng_y1   = eng_y1_q;
  assign eng_data = eng_data_q;

endmodule

// File: tb/tb_draw_cmd_scheduler.sv
// Bench for draw_cmd_scheduler: directed scenarios plus random traffic against a
// transaction-level model (RR pick, min/max/clamp, response deadline arithmetic).
module tb_draw_cmd_scheduler;

  localparam int NREQ = 4;
  localparam int XW   = 7;   // wide enough that x=70 exists and exercises the x clamp
  localparam int YW   = 6;
  localparam int XMAX = 63;
  localparam int YMAX = 47;
  localparam int CW   = 8;
  localparam int TOW  = 5;
  localparam int TMO  = 16;

  logic clk = 1'b0;
  logic rst;
  logic [NREQ-1:0]    req_vld, req_rdy, ack, err;
  logic [NREQ*XW-1:0] req_x0, req_x1;
  logic [NREQ*YW-1:0] req_y0, req_y1;
  logic [NREQ*CW-1:0] req_color;
  logic               busy, eng_vld, eng_done, eng_rst;
  logic [XW-1:0]      eng_x0, eng_x1;
  logic [YW-1:0]      eng_y0, eng_y1;
  logic [CW-1:0]      eng_data;

  always #5 clk = ~clk;

  draw_cmd_scheduler #(
    .NREQ(NREQ), .SPIXEL_X_WIDTH(XW), .SPIXEL_Y_WIDTH(YW), .SPIXEL_X_MAX(XMAX),
    .SPIXEL_Y_MAX(YMAX), .COLOR_ID_WIDTH(CW), .TO_WIDTH(TOW), .TIMEOUT(TMO)
  ) dut (
    .clk(clk), .rst(rst), .req_vld(req_vld), .req_rdy(req_rdy),
    .req_x0(req_x0), .req_y0(req_y0), .req_x1(req_x1), .req_y1(req_y1),
    .req_color(req_color), .ack(ack), .err(err), .busy(busy),
    .eng_x0(eng_x0), .eng_y0(eng_y0), .eng_x1(eng_x1), .eng_y1(eng_y1),
    .eng_data(eng_data), .eng_vld(eng_vld), .eng_done(eng_done), .eng_rst(eng_rst)
  );

  typedef struct { int g; int x0; int y0; int x1; int y1; int c; } txn_t;

  int   cx0[NREQ], cy0[NREQ], cx1[NREQ], cy1[NREQ], ccol[NREQ];
  txn_t exp_q[$];
  int   grant_log[$];
  int   resp_log[$];
  int   m_ptr, cyc, done_at, resp_at, resp_g, eng_delay;
  bit   resp_ack, rand_delay;
  int   n_checks, n_fail, n_launch, n_resp, n_err, n_issued;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic int onehot(input int g);
    return (g < 0) ? 0 : (1 << g);
  endfunction

  function automatic int imin(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  function automatic int imax(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // First pending client at or after ptr, wrapping.
  function automatic int pick(input logic [NREQ-1:0] v, input int ptr);
    for (int k = 0; k < NREQ; k++)
      if (v[(ptr + k) % NREQ]) return (ptr + k) % NREQ;
    return -1;
  endfunction

  // One clock: sample outputs on the falling edge, act as clients and engine.
  task automatic tick();
    @(negedge clk);
    cyc++;
    if (req_rdy != '0) begin
      int   g;
      txn_t t;
      g = pick(req_vld, m_ptr);
      check("grant", 64'(req_rdy), 64'(onehot(g)));
      if (g >= 0) begin
        t.g  = g;
        t.x0 = imin(imin(cx0[g], cx1[g]), XMAX);
        t.x1 = imin(imax(cx0[g], cx1[g]), XMAX);
        t.y0 = imin(imin(cy0[g], cy1[g]), YMAX);
        t.y1 = imin(imax(cy0[g], cy1[g]), YMAX);
        t.c  = ccol[g];
        exp_q.push_back(t);
        grant_log.push_back(g);
        m_ptr = (g + 1) % NREQ;
        req_vld[g] = 1'b0;
      end
    end
    if (eng_vld) begin
      n_launch++;
      if (exp_q.size() == 0) begin
        check("launch_unexpected", 64'(eng_vld), 64'(0));
      end else begin
        txn_t t;
        int   d;
        t = exp_q.pop_front();
        check("eng_x0", 64'(eng_x0), 64'(t.x0));
        check("eng_y0", 64'(eng_y0), 64'(t.y0));
        check("eng_x1", 64'(eng_x1), 64'(t.x1));
        check("eng_y1", 64'(eng_y1), 64'(t.y1));
        check("eng_data", 64'(eng_data), 64'(t.c));
        d = rand_delay ? int'($urandom_range(0, TMO + 4)) : eng_delay;
        done_at  = (d > 0) ? cyc + d : -1;
        resp_g   = t.g;
        // BUSY spans TMO cycles after the launch cycle; a done inside it is acked.
        resp_ack = (d > 0) && (d <= TMO);
        resp_at  = resp_ack ? cyc + d + 1 : cyc + TMO + 1;
      end
    end
    eng_done = (cyc == done_at);
    if (ack != '0 || err != '0 || eng_rst || cyc == resp_at) begin
      bit hit;
      hit = (cyc == resp_at);
      check("ack", 64'(ack), 64'((hit && resp_ack) ? onehot(resp_g) : 0));
      check("err", 64'(err), 64'((hit && !resp_ack) ? onehot(resp_g) : 0));
      check("eng_rst", 64'(eng_rst), 64'(hit && !resp_ack));
      if (err != '0) n_err++;
      if (hit) begin
        n_resp++;
        resp_log.push_back(resp_g);
        resp_at = -1;
      end
    end
  endtask

  task automatic do_reset();
    rst      = 1'b1;
    req_vld  = '0;
    eng_done = 1'b0;
    exp_q.delete();
    grant_log.delete();
    resp_log.delete();
    done_at  = -1;
    resp_at  = -1;
    m_ptr    = 0;
    n_resp   = 0;
    n_launch = 0;
    n_issued = 0;
    tick();
    rst = 1'b0;
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_rdy"}, 64'(req_rdy), 64'(0));
    check({tag, "_ack"}, 64'(ack), 64'(0));
    check({tag, "_err"}, 64'(err), 64'(0));
    check({tag, "_busy"}, 64'(busy), 64'(0));
    check({tag, "_vld"}, 64'(eng_vld), 64'(0));
    check({tag, "_rst"}, 64'(eng_rst), 64'(0));
    check({tag, "_coords"}, {eng_x0, eng_y0, eng_x1, eng_y1, eng_data}, 64'(0));
  endtask

  task automatic issue(input int i, input int x0, input int y0, input int x1, input int y1,
                       input int c);
    cx0[i] = x0; cy0[i] = y0; cx1[i] = x1; cy1[i] = y1; ccol[i] = c;
    req_x0[i*XW +: XW]    = XW'(x0);
    req_y0[i*YW +: YW]    = YW'(y0);
    req_x1[i*XW +: XW]    = XW'(x1);
    req_y1[i*YW +: YW]    = YW'(y1);
    req_color[i*CW +: CW] = CW'(c);
    req_vld[i] = 1'b1;
    n_issued++;
  endtask

  task automatic issue_rand(input int i);
    issue(i, int'($urandom_range(0, 127)), int'($urandom_range(0, 63)),
          int'($urandom_range(0, 127)), int'($urandom_range(0, 63)),
          int'($urandom_range(0, 255)));
  endtask

  task automatic wait_resp(input int target, input int budget);
    int n;
    n = 0;
    while (n_resp < target && n < budget) begin
      tick();
      n++;
    end
    if (n_resp < target) check("resp_timeout", 64'(n_resp), 64'(target));
  endtask

  task automatic wait_launch(input int target, input int budget);
    int n;
    n = 0;
    while (n_launch < target && n < budget) begin
      tick();
      n++;
    end
    if (n_launch < target) check("launch_timeout", 64'(n_launch), 64'(target));
  endtask

  initial begin
    rst = 1'b1; req_vld = '0; eng_done = 1'b0;
    req_x0 = '0; req_y0 = '0; req_x1 = '0; req_y1 = '0; req_color = '0;
    cyc = 0; n_checks = 0; n_fail = 0; n_err = 0;
    eng_delay = 5; rand_delay = 1'b0;

    do_reset();
    check_quiet("reset");

    // single command, unsorted corners
    eng_delay = 5;
    issue(0, 10, 5, 2, 20, 8'h3C);
    wait_resp(1, 100);
    tick();
    check("single_client", 64'(resp_log[0]), 64'(0));
    check("single_launches", 64'(n_launch), 64'(1));
    check("hold_x0", 64'(eng_x0), 64'(2));
    check("hold_y1", 64'(eng_y1), 64'(20));

    // clamp both axes
    issue(1, 70, 50, 0, 0, 8'hA5);
    wait_resp(2, 100);
    check("clamp_x1", 64'(eng_x1), 64'(63));
    check("clamp_y1", 64'(eng_y1), 64'(47));

    // round robin with every client re-requesting right after being taken
    do_reset();
    eng_delay = 10;
    for (int i = 0; i < NREQ; i++) issue_rand(i);
    for (int n = 0; n < 400 && n_resp < 5; n++) begin
      tick();
      if (req_rdy == '0)
        for (int i = 0; i < NREQ; i++) if (!req_vld[i]) issue_rand(i);
    end
    check("rr_resp_count", 64'(n_resp >= 5), 64'(1));
    for (int k = 0; k < 5; k++) begin
      check("rr_grant", 64'(grant_log[k]), 64'(k % NREQ));
      check("rr_ack", 64'(resp_log[k]), 64'(k % NREQ));
    end

    // wrap-around: ptr at 2 with clients 0 and 1 pending
    do_reset();
    eng_delay = 3;
    issue(1, 4, 4, 4, 4, 8'h11);
    wait_resp(1, 100);
    check("degenerate_x", {eng_x0, eng_x1}, {XW'(4), XW'(4)});
    issue(0, 1, 2, 3, 4, 8'h22);
    issue(1, 5, 6, 7, 8, 8'h33);
    wait_resp(3, 200);
    check("wrap_first", 64'(grant_log[1]), 64'(0));
    check("wrap_second", 64'(grant_log[2]), 64'(1));

    // watchdog abort then the next client is served
    eng_delay = 0;
    issue(2, 9, 9, 1, 1, 8'h44);
    wait_launch(4, 100);
    tick();
    check("busy_in_draw", 64'(busy), 64'(1));
    eng_delay = 3;
    issue(3, 0, 0, 8, 8, 8'h55);
    wait_resp(5, 200);
    check("abort_client", 64'(resp_log[3]), 64'(2));
    check("after_abort_client", 64'(resp_log[4]), 64'(3));
    check("abort_count", 64'(n_err), 64'(1));

    // done in the same cycle as the timeout
    eng_delay = TMO;
    issue(0, 3, 3, 30, 30, 8'h66);
    wait_resp(6, 200);
    check("done_wins_count", 64'(n_err), 64'(1));

    // reset in the middle of a draw
    eng_delay = 0;
    issue(1, 2, 2, 9, 9, 8'h77);
    wait_launch(n_launch + 1, 100);
    repeat (3) tick();
    do_reset();
    check_quiet("midreset");
    repeat (20) tick();
    check("midreset_no_resp", 64'(n_resp), 64'(0));
    eng_delay = 2;
    issue(3, 1, 1, 1, 1, 8'h88);
    issue(0, 2, 2, 2, 2, 8'h99);
    wait_resp(2, 200);
    check("midreset_ptr", 64'(grant_log[0]), 64'(0));

    // random traffic with random engine latency (some beyond the watchdog)
    do_reset();
    rand_delay = 1'b1;
    for (int n = 0; n < 6000 && n_issued < 150; n++) begin
      tick();
      if (req_rdy == '0)
        for (int i = 0; i < NREQ; i++)
          if (!req_vld[i] && $urandom_range(0, 7) == 0) issue_rand(i);
    end
    wait_resp(n_issued, 4000);
    check("rand_all_served", 64'(n_resp), 64'(n_issued));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
